mem_arbiter: RTL and testbench

Two-port memory arbiter between the instruction cache and the data cache on one side and the single-ported RAM on the other. It accepts read requests from the icache and read/write requests from the dcache. It grants one request at a time to the RAM and holds that grant until the RAM reports ACCESS. It routes the load data and wait signals back to the owning cache, and gives data priority over instructions with a bounded anti-starvation counter.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the memory arbiter.
// The arbiter takes the slave view; whatever drives the caches and the RAM takes the master view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter that puts icache reads and dcache reads/writes onto one RAM port, one grant at a time.
// Data is preferred, but only for a bounded streak, so instruction fetch always makes progress.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [1:0] ACCESS     = 2'd2;
    localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      state_next;
    logic [3:0]  streak;
    logic [3:0]  streak_next;
    logic        d_req;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= STREAK_LIM) ? STREAK_LIM : v + 4'd1;
    endfunction

    assign d_req = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // Every output is decoded from the registered state and the live inputs.
    always_comb begin
        state_next   = state;
        streak_next  = streak;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (d_req && (streak < STREAK_LIM || !bus.iREN)) begin
                    state_next = DGRANT;
                end else if (bus.iREN) begin
                    state_next = IGRANT;
                end
            end

            IGRANT: begin
                if (!bus.iREN) begin
                    state_next = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait   = 1'b0;
                        bus.iload   = bus.ramload;
                        state_next  = IDLE;
                        streak_next = '0;
                    end
                end
            end

            DGRANT: begin
                // A withdrawn request releases the RAM without completing and leaves streak alone.
                if (!d_req) begin
                    state_next = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    if (bus.dWEN) begin
                        bus.ramWEN = 1'b1;
                    end else begin
                        bus.ramREN = 1'b1;
                    end
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait   = 1'b0;
                        bus.dload   = bus.ramload;
                        state_next  = IDLE;
                        streak_next = bus.iREN ? sat_inc(streak) : 4'd0;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized icache/dcache traffic
// against a behavioural RAM, with a scoreboard monitor checking every completed access.
module tb_mem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ERROR = 2'd2 + 2'd1, ACCESS = 2'd2;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    logic CLK;
    logic RST;
    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int d_while_i = 0;

    exp_t iq[$];
    exp_t dq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    int ram_lat    = 1;
    int ram_busy_n = 1;
    bit ram_rand   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3C3, a[15:0] + 16'h1111};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : pat(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_ctl"}, {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN}, 4'b1100);
        check({name, "_bus"}, {bus.ramaddr, bus.ramstore}, 64'h0);
        check({name, "_load"}, {bus.iload, bus.dload}, 64'h0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit is_d, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CLK);
            if ((is_d ? bus.dwait : bus.iwait) == 1'b0) seen = 1'b1;
        end
        check({name, "_done"}, seen, 1);
    endtask

    task automatic push_i(input logic [31:0] a);
        iq.push_back('{1'b0, a, 32'h0, ref_rd(a)});
    endtask

    task automatic push_d(input bit w, input logic [31:0] a, input logic [31:0] s);
        if (w) begin
            dq.push_back('{1'b1, a, s, 32'h0});
            ref_mem[a] = s;
        end else begin
            dq.push_back('{1'b0, a, s, ref_rd(a)});
        end
    endtask

    // Behavioural RAM: ram_busy_n BUSY cycles, then ERROR until ram_lat, then one ACCESS cycle.
    initial begin
        int cnt = 0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (RST || !(bus.ramREN || bus.ramWEN)) begin
                bus.ramstate = FREE;
                bus.ramload  = '0;
                cnt = 0;
            end else begin
                if (cnt == 0 && ram_rand) begin
                    ram_lat    = $urandom_range(1, 4);
                    ram_busy_n = $urandom_range(0, ram_lat);
                end
                if (cnt < ram_lat) begin
                    bus.ramstate = (cnt < ram_busy_n) ? BUSY : ERROR;
                    bus.ramload  = '0;
                    cnt++;
                end else begin
                    bus.ramstate = ACCESS;
                    if (bus.ramWEN) begin
                        ram_mem[bus.ramaddr] = bus.ramstore;
                        bus.ramload = '0;
                    end else begin
                        bus.ramload = ram_rd(bus.ramaddr);
                    end
                    cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: each wait pulse retires the oldest expectation of that cache.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (!bus.iwait) begin
                    check("i_excl_dwait", bus.dwait, 1);
                    check("i_pending", iq.size() != 0, 1);
                    if (iq.size() != 0) begin
                        e = iq.pop_front();
                        check("i_op", {bus.ramREN, bus.ramWEN}, 2'b10);
                        check("i_addr", bus.ramaddr, e.addr);
                        check("i_store", bus.ramstore, e.store);
                        check("i_load", bus.iload, e.load);
                    end
                    d_while_i = 0;
                end
                if (!bus.dwait) begin
                    check("d_excl_iwait", bus.iwait, 1);
                    check("d_pending", dq.size() != 0, 1);
                    if (dq.size() != 0) begin
                        e = dq.pop_front();
                        check("d_op", {bus.ramWEN, bus.ramREN}, e.wen ? 2'b10 : 2'b01);
                        check("d_addr", bus.ramaddr, e.addr);
                        check("d_store", bus.ramstore, e.store);
                        check("d_load", bus.dload, e.load);
                    end
                    if (bus.iREN) begin
                        d_while_i++;
                        check("starve_bound", d_while_i <= STARVE_MAX, 1);
                    end else begin
                        d_while_i = 0;
                    end
                end
            end
        end
    end

    task automatic i_agent(input int n);
        for (int t = 0; t < n; t++) begin
            tick();
            bus.iREN = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            bus.iaddr = 32'(4 * $urandom_range(0, 63));
            bus.iREN  = 1'b1;
            push_i(bus.iaddr);
            wait_done(0, "rnd_i");
        end
        tick();
        bus.iREN = 1'b0;
    endtask

    task automatic d_agent(input int n);
        bit w;
        for (int t = 0; t < n; t++) begin
            tick();
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            w = ($urandom_range(0, 2) == 0);
            bus.daddr  = 32'h100 + 32'(4 * $urandom_range(0, 15));
            bus.dstore = $urandom;
            bus.dWEN   = w;
            bus.dREN   = w ? 1'($urandom_range(0, 1)) : 1'b1;
            push_d(w, bus.daddr, bus.dstore);
            wait_done(1, "rnd_d");
        end
        tick();
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    initial begin
        int dcnt, rounds, guard;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle("reset");
        tick();
        RST = 1'b0;

        // Single instruction read with a one-cycle RAM.
        ram_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h40; push_i(32'h40);
        @(negedge CLK); check("i_first_cycle_idle", bus.ramREN, 0);
        @(negedge CLK); check("i_grant", {bus.ramREN, bus.ramWEN, bus.ramaddr}, {2'b10, 32'h40});
        check("i_grant_wait", bus.iwait, 1);
        @(negedge CLK); check("i_access_wait", bus.iwait, 0);
        tick();
        bus.iREN = 1'b0;
        @(negedge CLK); check_idle("i_after");

        // Data write wins over a simultaneous instruction read.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        push_d(1, 32'h80, 32'h1234); push_i(32'h44);
        @(negedge CLK); check("wp_idle", {bus.ramREN, bus.ramWEN}, 2'b00);
        @(negedge CLK); check("wp_dgrant", {bus.ramWEN, bus.ramREN, bus.ramstore}, {2'b10, 32'h1234});
        check("wp_iwait", bus.iwait, 1);
        wait_done(1, "wp_d");
        tick();
        bus.dWEN = 1'b0;
        @(negedge CLK); check("wp_gap", {bus.ramREN, bus.ramWEN}, 2'b00);
        @(negedge CLK); check("wp_igrant", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h44});
        wait_done(0, "wp_i");
        tick();
        bus.iREN = 1'b0;

        // Anti-starvation: continuous data reads against a held instruction read, two rounds.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h48; push_i(32'h48);
        bus.dREN = 1'b1; bus.daddr = 32'h100; bus.dstore = $urandom;
        push_d(0, bus.daddr, bus.dstore);
        dcnt = 0; rounds = 0; guard = 0;
        while (rounds < 2 && guard < 300) begin
            @(negedge CLK);
            guard++;
            if (!bus.dwait) begin
                dcnt++;
                tick();
                bus.daddr = 32'h100 + 32'(4 * (dcnt + 8 * rounds));
                bus.dstore = $urandom;
                push_d(0, bus.daddr, bus.dstore);
            end else if (!bus.iwait) begin
                check($sformatf("starve_round%0d", rounds), dcnt, STARVE_MAX);
                rounds++;
                dcnt = 0;
                tick();
                if (rounds < 2) begin
                    bus.iaddr = 32'h48 + 32'(4 * rounds);
                    push_i(bus.iaddr);
                end else begin
                    bus.iREN = 1'b0;
                end
            end
        end
        check("starve_rounds", rounds, 2);
        wait_done(1, "starve_tail");
        tick();
        bus.dREN = 1'b0;

        // Slow RAM: 5 BUSY, 2 ERROR, then ACCESS.
        ram_lat = 7; ram_busy_n = 5;
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h84; bus.dstore = $urandom;
        push_d(0, 32'h84, bus.dstore);
        @(negedge CLK);
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            check($sformatf("slow_hold%0d", k), {bus.dwait, bus.ramREN, bus.ramaddr}, {2'b11, 32'h84});
        end
        @(negedge CLK); check("slow_access", bus.dwait, 0);
        tick();
        bus.dREN = 1'b0;

        // Request withdrawn in the second DGRANT cycle.
        ram_lat = 3; ram_busy_n = 3;
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h88;
        @(negedge CLK);
        @(negedge CLK); check("abort_grant", bus.ramREN, 1);
        tick();
        bus.dREN = 1'b0;
        @(negedge CLK); check("abort_drop", {bus.ramREN, bus.ramWEN, bus.dwait}, 3'b001);
        @(negedge CLK); check_idle("abort_idle");

        // Reset pulsed in the middle of an instruction grant.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h4C;
        @(negedge CLK);
        @(negedge CLK); check("rst_pre", bus.ramREN, 1);
        #1 RST = 1'b1;
        #1 check_idle("rst_mid");
        @(posedge CLK);
        #1 RST = 1'b0;
        bus.iREN = 1'b0; ram_lat = 1; ram_busy_n = 1;
        @(negedge CLK); check_idle("rst_after");

        // dREN and dWEN together: only the write is issued; then read it back.
        tick();
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h90; bus.dstore = 32'hCAFEF00D;
        push_d(1, 32'h90, 32'hCAFEF00D);
        @(negedge CLK);
        @(negedge CLK); check("both_wen_only", {bus.ramWEN, bus.ramREN}, 2'b10);
        wait_done(1, "both_w");
        tick();
        bus.dWEN = 1'b0;
        push_d(0, 32'h90, bus.dstore);
        wait_done(1, "both_rb");
        tick();
        bus.dREN = 1'b0;

        // Randomized concurrent traffic with random RAM latency.
        ram_rand = 1'b1;
        fork
            i_agent(40);
            d_agent(60);
        join
        repeat (3) tick();
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run still active at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
